// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//
// Writer side of the MiniAlu instruction path. A host pushes a program as a
// byte stream:
//     LEN_HI, LEN_LO (word count N, big-endian),
//     N x 4 instruction bytes (most significant byte first),
//     one checksum byte (XOR of every preceding byte of the stream).
// Every four instruction bytes are assembled into a 28-bit word and written
// to the instruction RAM at consecutive addresses starting at 0. The CPU is
// held in reset until a complete program whose checksum matches is loaded.
//
// Ports
//   Clock          single clock, rising edge
//   Reset          synchronous, active-high; aborts any load, back to IDLE
//   iStart         load request, honoured only in IDLE / DONE / ERROR
//   iByteValid     iByte holds a valid byte
//   iByte[7:0]     stream byte
//   oByteReady     loader accepts a byte this cycle (decoded from state)
//   oWriteEnable   one-cycle instruction memory write strobe
//   oWriteAddress  word address of the write
//   oInstruction   instruction word to write
//   oCpuReset      CPU reset, high while no verified program is present
//   oDone          level, last load succeeded
//   oError         level, last load failed (bad length or bad checksum)
// ---------------------------------------------------------------------------
module program_loader #(
    parameter int MAX_WORDS = 256
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        iStart,
    input  logic        iByteValid,
    input  logic [7:0]  iByte,
    output logic        oByteReady,
    output logic        oWriteEnable,
    output logic [15:0] oWriteAddress,
    output logic [27:0] oInstruction,
    output logic        oCpuReset,
    output logic        oDone,
    output logic        oError
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        BYTE   = 3'd3,
        WRITE  = 3'd4,
        CHECK  = 3'd5,
        DONE   = 3'd6,
        ERROR  = 3'd7
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    logic [15:0] len_reg;        // program length N in words
    logic [15:0] count_reg;      // words written so far
    logic [15:0] addr_reg;       // address of the next write
    logic [1:0]  idx_reg;        // byte index within the current word
    logic [7:0]  csum_reg;       // running XOR of the stream
    logic        cpu_reset_reg;
    logic        done_reg;
    logic        error_reg;

    // Assembly register split into byte lanes. lane_reg[0] holds bits [7:0],
    // lane_reg[2] bits [23:16]; top_reg holds the low nibble of byte0.
    logic [7:0]  lane_reg [0:2];
    logic [3:0]  top_reg;

    logic        byte_fire;      // a byte transfers on this edge
    logic        start_ok;       // iStart honoured in this state
    logic [15:0] length_full;    // N as seen while the low byte arrives
    logic        last_word;      // the write in progress is word N-1

    // oByteReady comes from state_reg only, so byte_fire has no loop
    // through the ready output.
    assign byte_fire   = iByteValid & oByteReady;
    assign start_ok    = iStart & ((state_reg == IDLE) || (state_reg == DONE) ||
                                   (state_reg == ERROR));
    assign length_full = {len_reg[15:8], iByte};
    assign last_word   = ((count_reg + 16'd1) == len_reg);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE, ERROR: begin
                if (start_ok) begin
                    state_next = LEN_HI;
                end
            end
            LEN_HI: begin
                if (byte_fire) begin
                    state_next = LEN_LO;
                end
            end
            LEN_LO: begin
                if (byte_fire) begin
                    if (length_full == 16'd0) begin
                        state_next = CHECK;
                    end else if (length_full > MAX_LEN) begin
                        state_next = ERROR;
                    end else begin
                        state_next = BYTE;
                    end
                end
            end
            BYTE: begin
                if (byte_fire && (idx_reg == 2'd3)) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                state_next = last_word ? CHECK : BYTE;
            end
            CHECK: begin
                if (byte_fire) begin
                    state_next = (iByte == csum_reg) ? DONE : ERROR;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic: decoded from state or taken straight from registers
    // -----------------------------------------------------------------------
    always_comb begin
        oByteReady    = 1'b0;
        oWriteEnable  = 1'b0;
        oWriteAddress = addr_reg;
        oInstruction  = {top_reg, lane_reg[2], lane_reg[1], lane_reg[0]};
        oCpuReset     = cpu_reset_reg;
        oDone         = done_reg;
        oError        = error_reg;
        case (state_reg)
            LEN_HI, LEN_LO, BYTE, CHECK: oByteReady = 1'b1;
            // A reset arriving during the write cycle must not let the
            // strobe reach the RAM, so it is masked here as well.
            WRITE:                       oWriteEnable = ~Reset;
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Control and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            len_reg       <= 16'd0;
            count_reg     <= 16'd0;
            addr_reg      <= 16'd0;
            idx_reg       <= 2'd0;
            csum_reg      <= 8'd0;
            cpu_reset_reg <= 1'b1;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE, ERROR: begin
                    if (start_ok) begin
                        count_reg     <= 16'd0;
                        addr_reg      <= 16'd0;
                        idx_reg       <= 2'd0;
                        csum_reg      <= 8'd0;
                        cpu_reset_reg <= 1'b1;
                        done_reg      <= 1'b0;
                        error_reg     <= 1'b0;
                    end
                end
                LEN_HI: begin
                    if (byte_fire) begin
                        len_reg[15:8] <= iByte;
                        csum_reg      <= csum_reg ^ iByte;
                    end
                end
                LEN_LO: begin
                    if (byte_fire) begin
                        len_reg[7:0] <= iByte;
                        csum_reg     <= csum_reg ^ iByte;
                        idx_reg      <= 2'd0;
                        if (length_full > MAX_LEN) begin
                            error_reg <= 1'b1;
                        end
                    end
                end
                BYTE: begin
                    if (byte_fire) begin
                        // byte0 bits [7:4] are dropped from the word but
                        // still count towards the checksum.
                        csum_reg <= csum_reg ^ iByte;
                        idx_reg  <= idx_reg + 2'd1;
                    end
                end
                WRITE: begin
                    addr_reg  <= addr_reg + 16'd1;
                    count_reg <= count_reg + 16'd1;
                end
                CHECK: begin
                    if (byte_fire) begin
                        if (iByte == csum_reg) begin
                            done_reg      <= 1'b1;
                            cpu_reset_reg <= 1'b0;
                        end else begin
                            error_reg     <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Assembly lanes: byte index k lands in lane 3-k (big-endian word).
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            localparam logic [1:0] LANE_IDX = 2'(3 - gi);
            always_ff @(posedge Clock) begin
                if (Reset) begin
                    lane_reg[gi] <= 8'd0;
                end else if ((state_reg == BYTE) && byte_fire &&
                             (idx_reg == LANE_IDX)) begin
                    lane_reg[gi] <= iByte;
                end
            end
        end
    endgenerate

    always_ff @(posedge Clock) begin
        if (Reset) begin
            top_reg <= 4'd0;
        end else if ((state_reg == BYTE) && byte_fire && (idx_reg == 2'd0)) begin
            top_reg <= iByte[3:0];
        end
    end

endmodule
